// File: rtl/wb_stage.sv
// Writeback stage: captures one MEM-stage result per cycle, selects the
// writeback source, extracts/extends load data and drives one registered
// register-file write. Also counts retired instructions.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    input  logic             stall,
    input  logic             flush,
    input  logic             inRegWrite,
    input  logic [4:0]       inRd,
    input  logic [1:0]       inWbSel,
    input  logic [2:0]       inFunct3,
    input  logic [XLEN-1:0]  inAluResult,
    input  logic [XLEN-1:0]  inMemData,
    input  logic [XLEN-1:0]  inPc,
    input  logic [XLEN-1:0]  inImm,
    output logic             isWrite,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  writeData,
    output logic             wbValid,
    output logic [CNT_W-1:0] retireCount
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_is_write;
    logic              w_capture;

    logic              r_valid;
    logic              r_is_write;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_write_data;
    logic [CNT_W-1:0]  r_retire_count;

    // Load lane extraction: byte by full offset, half by offset bit 1
    always_comb begin
        w_byte = inMemData[BYTE_W*inAluResult[1:0] +: BYTE_W];
        w_half = inAluResult[1] ? inMemData[XLEN-1:HALF_W] : inMemData[HALF_W-1:0];
        case (inFunct3)
            F3_LB:   w_load_data = {{(XLEN-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            F3_LBU:  w_load_data = {{(XLEN-BYTE_W){1'b0}}, w_byte};
            F3_LH:   w_load_data = {{(XLEN-HALF_W){w_half[HALF_W-1]}}, w_half};
            F3_LHU:  w_load_data = {{(XLEN-HALF_W){1'b0}}, w_half};
            default: w_load_data = inMemData;
        endcase
    end

    // Writeback source select
    always_comb begin
        case (inWbSel)
            SEL_ALU:  w_sel_data = inAluResult;
            SEL_LOAD: w_sel_data = w_load_data;
            SEL_PC4:  w_sel_data = inPc + XLEN'(4);
            default:  w_sel_data = inImm;
        endcase
    end

    // Write enable never targets x0; capture only when neither flushed nor stalled
    always_comb begin
        w_is_write = inValid & inRegWrite & (inRd != 5'd0);
        w_capture  = ~flush & ~stall;
    end

    // Stage register and retire counter; flush outranks stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_is_write     <= 1'b0;
            r_rd           <= 5'd0;
            r_write_data   <= '0;
            r_retire_count <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_is_write <= 1'b0;
        end else if (w_capture) begin
            r_valid      <= inValid;
            r_is_write   <= w_is_write;
            r_rd         <= inRd;
            r_write_data <= w_sel_data;
            if (inValid) begin
                r_retire_count <= r_retire_count + CNT_W'(1);
            end
        end
    end

    assign wbValid     = r_valid;
    assign isWrite     = r_is_write;
    assign rd          = r_rd;
    assign writeData   = r_write_data;
    assign retireCount = r_retire_count;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage for the single-issue RV32I pipeline. It is the write-side driver of the register file.
- Each cycle it captures one MEM-stage result and selects the writeback source. For loads it performs byte/halfword extraction with sign or zero extension.
- It presents one registered write (isWrite, rd, writeData) to the register file.
- It also keeps a retired-instruction counter for debug and performance readout.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of retireCount.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inValid  input  1  MEM stage presents an instruction
- stall  input  1  hold the stage register; new input is not captured
- flush  input  1  kill the captured instruction; has priority over stall
- inRegWrite  input  1  instruction writes rd
- inRd  input  5  destination register
- inWbSel  input  2  source select: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- inFunct3  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- inAluResult  input  XLEN  ALU result; also the load address
- inMemData  input  XLEN  raw aligned word from data memory
- inPc  input  XLEN  instruction PC
- inImm  input  XLEN  U-type immediate
- isWrite  output  1  register-file write enable
- rd  output  5  register-file write address
- writeData  output  XLEN  register-file write data
- wbValid  output  1  stage holds a live instruction
- retireCount  output  CNT_W  count of instructions retired

Behaviour:
- Reset: asynchronous; takes effect immediately on rst_n low.
  - wbValid, isWrite, rd, writeData and retireCount are all 0, including when reset is asserted mid-operation.
  - The first capture occurs on the first rising edge after rst_n deasserts.
- Capture is registered with one-cycle latency: inputs present at edge N appear on the outputs after edge N.
- Edge priority:
  1. flush=1: wbValid<=0, isWrite<=0. rd and writeData may hold stale values. retireCount is not incremented.
  2. Otherwise stall=1: all outputs hold their values; no increment.
  3. Otherwise: wbValid<=inValid; rd<=inRd; writeData<=selected data.
- isWrite <= inValid & inRegWrite & (inRd != 0). A write to x0 is never issued.
- retireCount increments by 1 on each edge where inValid=1, stall=0 and flush=0. It wraps modulo 2^CNT_W with no saturation.
- While stall holds a live write, isWrite stays high. The register file rewrites the same value, which is idempotent and legal.
- Source select:
  - 00 -> inAluResult
  - 10 -> inPc + 4, modulo 2^32 (0xFFFFFFFC -> 0)
  - 11 -> inImm
- Load extraction (inWbSel=01), with off = inAluResult[1:0]:
  - LB/LBU: byte inMemData[8*off+7 : 8*off]. LB sign-extends from bit 7; LBU zero-extends.
  - LH/LHU: half select by off[1] (0 -> [15:0], 1 -> [31:16]); off[0] is ignored. LH sign-extends from bit 15; LHU zero-extends.
  - LW: full word; off is ignored.
  - funct3 011, 110, 111: treated as LW.
- Masking: when inRegWrite=0 or inRd=0, writeData is still captured but isWrite=0.
- No combinational path from any input to any output.

Test Plan:
- Reset: rst_n=0 mid-stream with isWrite=1 and retireCount=5 -> all outputs 0 immediately, with no clock edge needed.
- ALU and x0 writes:
  - inValid=1, inRegWrite=1, inRd=5, inWbSel=00, inAluResult=0x12345678 -> next cycle isWrite=1, rd=5, writeData=0x12345678, retireCount=1.
  - Same stimulus with inRd=0 -> isWrite=0, retireCount=2.
- Load extraction, inMemData=0x80FF7F01:
  - LB, off=3 -> 0xFFFFFF80
  - LBU, off=3 -> 0x00000080
  - LH, off=2 -> 0xFFFF80FF
  - LHU, off=0 -> 0x00007F01
  - LW, off=1 -> 0x80FF7F01
- PC+4 and LUI:
  - inWbSel=10, inPc=0xFFFFFFFC -> writeData=0x00000000
  - inWbSel=11, inImm=0xABCDE000 -> writeData=0xABCDE000
- Stall/flush:
  - Load rd=7 = 0x11, then stall=1 for 3 cycles with new input rd=8 -> outputs hold rd=7/0x11; retireCount unchanged.
  - Assert stall=1 and flush=1 together -> next cycle wbValid=0, isWrite=0, no increment.
- Counter wrap: CNT_W=4, retire 17 valid instructions -> retireCount=1.
